// File: rtl/mux_rr_scheduler_if.sv
// Requester/consumer bundle for the shared 8:1 byte mux scheduler.
// master: scheduler side; slave: requesters plus downstream consumer.
interface mux_rr_scheduler_if #(
  parameter int NREQ = 8,
  parameter int DW   = 8,
  parameter int SELW = $clog2(NREQ)
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    gnt;
  logic [SELW-1:0]    sel;
  logic [DW-1:0]      dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               busy;

  modport master (
    input  req, din, dout_ready,
    output ack, gnt, sel, dout, dout_valid, busy
  );

  modport slave (
    output req, din, dout_ready,
    input  ack, gnt, sel, dout, dout_valid, busy
  );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin grant of one registered byte mux among NREQ requesters,
// up to MAX_BURST beats per grant, valid/ready output register.
// Ports: clk, rst (sync, active-high), bus (mux_rr_scheduler_if.master):
//   req/din in, ack/gnt/sel out, dout/dout_valid out, dout_ready in, busy out.
// Option: define MUX_SCHED_FIXED_PRI_EN for lowest-index-wins arbitration.
module mux_rr_scheduler #(
  parameter int NREQ      = 8,
  parameter int DW        = 8,
  parameter int SELW      = $clog2(NREQ),
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux_rr_scheduler_if.master  bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dv_q, dv_d;

  logic [SELW-1:0] win;
  logic            found;
  logic            load;
  logic [DW-1:0]   din_sel;

  // Winner search; the loop runs from farthest to nearest candidate so
  // the nearest requester overwrites earlier hits.
  always_comb begin
    win   = '0;
    found = 1'b0;
`ifdef MUX_SCHED_FIXED_PRI_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win   = SELW'(i);
        found = 1'b1;
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[(int'(last_q) + k) % NREQ]) begin
        win   = SELW'((int'(last_q) + k) % NREQ);
        found = 1'b1;
      end
    end
`endif
  end

  assign din_sel = bus.din[int'(sel_q)*DW +: DW];

  assign load = (state_q == GRANT)
             && bus.req[sel_q]
             && (!dv_q || bus.dout_ready)
             && (cnt_q < CW'(MAX_BURST));

  always_comb begin
    bus.ack = '0;
    if (load && !rst)
      bus.ack[sel_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = dv_q;

    // Output register runs independently of the grant so a pending
    // beat can drain after release.
    if (load) begin
      dout_d = din_sel;
      dv_d   = 1'b1;
    end else if (bus.dout_ready) begin
      dv_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << win;
          sel_d   = win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (load)
          cnt_d = cnt_q + CW'(1);
        if (!bus.req[sel_q] ||
            (load && cnt_q == CW'(MAX_BURST - 1))) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SELW'(NREQ - 1);
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.busy       = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: MAX_BURST=4 and MAX_BURST=1
// instances, hand-computed expectations.
module tb_mux_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_rr_scheduler_if #(.NREQ(8), .DW(8), .SELW(3)) bus ();
  mux_rr_scheduler_if #(.NREQ(8), .DW(8), .SELW(3)) bus1 ();

  mux_rr_scheduler #(
    .NREQ(8), .DW(8), .SELW(3), .MAX_BURST(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  mux_rr_scheduler #(
    .NREQ(8), .DW(8), .SELW(3), .MAX_BURST(1)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] d3;
  logic [2:0]  exp7 [4];

  initial begin
    bus.req         = 8'hFF;
    bus.din         = '0;
    bus.dout_ready  = 1'b1;
    bus1.req        = '0;
    bus1.din        = '0;
    bus1.dout_ready = 1'b1;

    // reset
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_dv", 32'(bus.dout_valid), 32'h0);
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);

    // single requester, full burst, regrant
    rst = 1'b0;
    bus.req = 8'h08;
    bus.din[3*8 +: 8] = 8'ha3;
    tick();
    chk("t2_gnt", 32'(bus.gnt), 32'h08);
    chk("t2_sel", 32'(bus.sel), 32'd3);
    chk("t2_busy", 32'(bus.busy), 32'h1);
    for (int b = 0; b < 4; b++) begin
      chk("t2_ack", 32'(bus.ack), 32'h08);
      tick();
      chk("t2_dout", 32'(bus.dout), 32'ha3);
      chk("t2_dv", 32'(bus.dout_valid), 32'h1);
    end
    chk("t2_rel_gnt", 32'(bus.gnt), 32'h0);
    chk("t2_idle_ack", 32'(bus.ack), 32'h0);
    tick();
    chk("t2_regnt", 32'(bus.gnt), 32'h08);
    bus.req = 8'h00;
    #1;
    chk("t2_drop_ack", 32'(bus.ack), 32'h0);
    tick();
    chk("t2_drop_gnt", 32'(bus.gnt), 32'h0);

    // backpressure on ch0
    bus.req = 8'h01;
    bus.din[0 +: 8] = 8'h11;
    tick();
    chk("t4_sel", 32'(bus.sel), 32'd0);
    tick();
    chk("t4_dout1", 32'(bus.dout), 32'h11);
    bus.dout_ready = 1'b0;
    bus.din[0 +: 8] = 8'h22;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t4_bp_ack", 32'(bus.ack), 32'h0);
      tick();
      chk("t4_bp_dout", 32'(bus.dout), 32'h11);
      chk("t4_bp_gnt", 32'(bus.gnt), 32'h01);
    end
    bus.dout_ready = 1'b1;
    #1;
    chk("t4_res_ack", 32'(bus.ack), 32'h01);
    tick();
    chk("t4_dout2", 32'(bus.dout), 32'h22);
    bus.din[0 +: 8] = 8'h33;
    tick();
    chk("t4_dout3", 32'(bus.dout), 32'h33);
    bus.din[0 +: 8] = 8'h44;
    tick();
    chk("t4_dout4", 32'(bus.dout), 32'h44);
    chk("t4_rel", 32'(bus.gnt), 32'h0);
    bus.req = 8'h00;
    tick();
    chk("t4_drain", 32'(bus.dout_valid), 32'h0);

    // ch5 drops after 2 beats, ch6 follows
    bus.req = 8'h60;
    tick();
    chk("t5_sel5", 32'(bus.sel), 32'd5);
    tick();
    tick();
    bus.req = 8'h40;
    #1;
    chk("t5_drop_ack", 32'(bus.ack), 32'h0);
    tick();
    chk("t5_rel_gnt", 32'(bus.gnt), 32'h0);
    chk("t5_rel_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("t5_gnt6", 32'(bus.gnt), 32'h40);
    chk("t5_sel6", 32'(bus.sel), 32'd6);
    bus.req = 8'h00;
    tick();

    // reset mid-burst of ch2
    bus.req = 8'h04;
    bus.din[2*8 +: 8] = 8'hc2;
    tick();
    chk("t6_sel2", 32'(bus.sel), 32'd2);
    tick();
    chk("t6_dout", 32'(bus.dout), 32'hc2);
    rst = 1'b1;
    #1;
    chk("t6_rst_ack", 32'(bus.ack), 32'h0);
    tick();
    chk("t6_gnt", 32'(bus.gnt), 32'h0);
    chk("t6_dout0", 32'(bus.dout), 32'h0);
    chk("t6_dv", 32'(bus.dout_valid), 32'h0);
    chk("t6_sel", 32'(bus.sel), 32'h0);
    chk("t6_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    tick();
    chk("t6_regnt", 32'(bus.gnt), 32'h04);
    chk("t6_resel", 32'(bus.sel), 32'd2);
    bus.req = 8'h00;
    tick();

    // MAX_BURST=1 rotation over all requesters
    d3 = 64'h93_67_ff_3d_a3_45_12_34;
    bus1.din = d3;
    bus1.req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t3_sel", 32'(bus1.sel), 32'(i % 8));
      chk("t3_gnt", 32'(bus1.gnt), 32'(1 << (i % 8)));
      tick();
      chk("t3_dout", 32'(bus1.dout), 32'(d3[(i % 8)*8 +: 8]));
    end

    // ch0 and ch7 contending
`ifdef MUX_SCHED_FIXED_PRI_EN
    exp7 = '{3'd0, 3'd0, 3'd0, 3'd0};
`else
    exp7 = '{3'd7, 3'd0, 3'd7, 3'd0};
`endif
    bus1.req = 8'h81;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t7_sel", 32'(bus1.sel), 32'(exp7[j]));
      tick();
    end
    bus1.req = 8'h00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
